// File: rtl/ws2812_pixel_rx.sv
// ws2812_pixel_rx: receiving end of the single-wire WS2812 / NeoPixel stream.
//
// The first 24 bits after a reset gap are decoded (MSB first, G7..G0, R7..R0,
// B7..B0) and presented on o_green/o_red/o_blue with a one-cycle o_valid.
// Every later bit of the same frame is replayed on o_dout, so several units
// can be chained like real WS2812 parts.
//
// Ports
//   CLK      system clock (12 MHz)
//   RST      synchronous reset, active-high
//   i_din    asynchronous WS2812 data line
//   o_dout   forwarded stream for the next device (pin delayed by 3 clocks)
//   o_valid  one-cycle strobe, colour bytes updated
//   o_green  decoded green byte
//   o_red    decoded red byte
//   o_blue   decoded blue byte
//   o_frame  one-cycle strobe, reset gap (latch) detected
//   o_error  one-cycle strobe, protocol error
//   o_state  current FSM state (debug view: 0 WAIT_GAP, 1 READY, 2 FORWARD)
//
// Strobe semantics: o_valid, o_frame and o_error are single-cycle pulses with
// no back-pressure; a consumer must sample them on the cycle they are high.
// Colour bytes hold until the next complete pixel.
module ws2812_pixel_rx #(
    parameter int BIT_THRESH   = 7,
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = 600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_din,
    output logic       o_dout,
    output logic       o_valid,
    output logic [7:0] o_green,
    output logic [7:0] o_red,
    output logic [7:0] o_blue,
    output logic       o_frame,
    output logic       o_error,
    output logic [1:0] o_state
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    localparam logic [HW-1:0] H_THRESH = HW'(BIT_THRESH);
    localparam logic [HW-1:0] H_MAX    = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_SAT    = HW'(MAX_HIGH + 1);
    localparam logic [LW-1:0] L_SAT    = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] L_PRE    = LW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        READY    = 2'd1,
        FORWARD  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            sync1, s_din, s_din_q;
    logic [HW-1:0]   hcnt;
    logic [LW-1:0]   lcnt;
    logic [4:0]      bcnt, bcnt_n;
    logic [22:0]     sr, sr_n;
    logic            load, frame_n, error_n, dout_n;

    logic            fall;
    logic            bit_val;
    logic            high_err;
    logic            gap_event;
    logic [23:0]     pixel;

    assign fall      = !s_din && s_din_q;
    // hcnt still holds the full high time on the cycle the fall is seen.
    assign bit_val   = (hcnt >= H_THRESH);
    assign high_err  = (hcnt > H_MAX);
    // Fires on the single cycle where lcnt steps to its saturation value, so
    // a long gap produces exactly one frame event.
    assign gap_event = !s_din && (lcnt == L_PRE);
    assign pixel     = {sr, bit_val};
    assign o_state   = state;

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        sr_n    = sr;
        load    = 1'b0;
        frame_n = 1'b0;
        error_n = 1'b0;
        dout_n  = 1'b0;
        case (state)
            WAIT_GAP: begin
                if (gap_event || (lcnt == L_SAT)) begin
                    state_n = READY;
                end
            end
            READY: begin
                if (high_err) begin
                    error_n = 1'b1;
                    bcnt_n  = '0;
                    state_n = WAIT_GAP;
                end else if (gap_event) begin
                    // A gap with a partial pixel pending is a truncated frame.
                    frame_n = 1'b1;
                    error_n = (bcnt != 5'd0);
                    bcnt_n  = '0;
                end else if (fall) begin
                    sr_n = pixel[22:0];
                    if (bcnt == 5'd23) begin
                        load    = 1'b1;
                        bcnt_n  = '0;
                        state_n = FORWARD;
                    end else begin
                        bcnt_n = bcnt + 5'd1;
                    end
                end
            end
            FORWARD: begin
                if (high_err) begin
                    error_n = 1'b1;
                    state_n = WAIT_GAP;
                end else if (gap_event) begin
                    frame_n = 1'b1;
                    state_n = READY;
                end else begin
                    dout_n = s_din;
                end
            end
            default: begin
                state_n = WAIT_GAP;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= 1'b0;
            s_din   <= 1'b0;
            s_din_q <= 1'b0;
            hcnt    <= '0;
            lcnt    <= '0;
            state   <= WAIT_GAP;
            bcnt    <= '0;
            sr      <= '0;
            o_dout  <= 1'b0;
            o_valid <= 1'b0;
            o_frame <= 1'b0;
            o_error <= 1'b0;
            o_green <= 8'h00;
            o_red   <= 8'h00;
            o_blue  <= 8'h00;
        end else begin
            sync1   <= i_din;
            s_din   <= sync1;
            s_din_q <= s_din;
            if (s_din) begin
                lcnt <= '0;
                if (hcnt != H_SAT) hcnt <= hcnt + 1'b1;
            end else begin
                hcnt <= '0;
                if (lcnt != L_SAT) lcnt <= lcnt + 1'b1;
            end
            state   <= state_n;
            bcnt    <= bcnt_n;
            sr      <= sr_n;
            o_dout  <= dout_n;
            o_valid <= load;
            o_frame <= frame_n;
            o_error <= error_n;
            if (load) begin
                o_green <= pixel[23:16];
                o_red   <= pixel[15:8];
                o_blue  <= pixel[7:0];
            end
        end
    end

endmodule

// File: doc/ws2812_pixel_rx.md
Name: ws2812_pixel_rx

Overview:
- Receiving end of the single-wire WS2812/NeoPixel protocol driven by our pixel writer.
- Decodes the first 24-bit pixel of each frame into G/R/B bytes and presents it with a valid strobe.
- Re-drives all later bits on o_dout, like a real WS2812 chain element, so units can be daisy-chained on PMOD pins.
- Used as an on-board loopback checker for the writer and as a chain-able pixel sink.

Parameters:
- BIT_THRESH, 7: high-time threshold in clocks; high time >= 7 decodes as 1, otherwise 0 (0.58 us at 12 MHz).
- MAX_HIGH, 24: longest legal high time in clocks; longer is a protocol error.
- RESET_CYCLES, 600: low time in clocks that ends a frame (50 us at 12 MHz).

Ports:
- CLK  in  1  system clock (12 MHz).
- RST  in  1  synchronous reset, active-high.
- i_din  in  1  asynchronous WS2812 data line.
- o_dout  out  1  forwarded data stream for the next device in the chain.
- o_valid  out  1  one-cycle strobe: o_green/o_red/o_blue updated.
- o_green  out  8  decoded green byte.
- o_red  out  8  decoded red byte.
- o_blue  out  8  decoded blue byte.
- o_frame  out  1  one-cycle strobe: reset gap (latch) detected.
- o_error  out  1  one-cycle strobe: protocol error.

Behaviour:
- Reset state: o_dout=0, o_valid=0, o_frame=0, o_error=0, colour bytes=0x00, state=WAIT_GAP, counters cleared, bit count=0.
- Input path: i_din passes through 2-FF synchroniser, then an edge-detect register. All timing uses the synchronised signal s_din. Rise/fall are detected 3 clocks after the pin edge.
- Timing counters:
  - hcnt counts clocks while s_din=1; lcnt counts clocks while s_din=0.
  - Each clears on the opposite edge.
  - Each saturates at its limit (MAX_HIGH+1, RESET_CYCLES) and does not wrap.
- States:
  - WAIT_GAP: ignores data; o_dout=0. Goes to READY when lcnt reaches RESET_CYCLES. No o_frame from this state.
  - READY/DECODE: on each falling edge, bit = (hcnt >= BIT_THRESH). Bits shift in MSB first, order G7..G0, R7..R0, B7..B0.
    - On the 24th bit, bytes load into o_green/o_red/o_blue and o_valid pulses on the next clock. State goes to FORWARD.
  - FORWARD: o_dout = s_din, registered (o_dout lags the pin by 3 clocks). No further decoding. Pulse widths pass through unchanged.
- Frame end: in READY or FORWARD, when lcnt reaches RESET_CYCLES:
  - o_frame pulses once; the gap is held by counter saturation.
  - o_dout is forced 0, bit count clears, state goes to READY.
  - If 1..23 bits were pending, they are discarded, o_error also pulses, and outputs are unchanged.
- Protocol error: hcnt exceeds MAX_HIGH in READY or FORWARD:
  - o_error pulses once.
  - Partial bits are discarded, o_dout is forced 0, state goes to WAIT_GAP.
- Colour outputs hold their value until the next full pixel. o_valid never coincides with o_frame.
- RST mid-frame: immediate return to the reset state. A transfer already in progress is then ignored until a full gap is seen, because WAIT_GAP is entered.
- Glitch rule: a high pulse of 1 clock is decoded as 0. No separate filter.

Test Plan:
- Startup gap then one pixel.
  - Stimulus: after RST, hold 0 for 600 clks. Send G=0x00 R=0x00 B=0x80, with 0-bits as 5H/10L and 1-bits as 10H/5L, then 700 clks low.
  - Required: one o_valid; green=0x00, red=0x00, blue=0x80; o_dout stays 0; one o_frame.
- Chain forwarding.
  - Stimulus: send pixels 0x123456 then 0xA5C3FF back-to-back, then gap.
  - Required: outputs G=0x12 R=0x34 B=0x56. o_dout replays exactly the second 24 bits, delayed 3 clocks, with identical pulse widths.
- Threshold boundary.
  - Stimulus: bits with high time 6 and 7 clocks.
  - Required: decoded as 0 and 1 respectively. A 1-clock high decodes as 0.
- Truncated frame.
  - Stimulus: send 10 bits, then 600 clks low.
  - Required: o_error and o_frame each pulse once; o_valid stays 0; previous colours retained.
- Stuck-high line.
  - Stimulus: hold 1 for 30 clks mid-pixel.
  - Required: o_error pulses at hcnt=25; no decode until 600-clk gap; the next pixel decodes correctly.
- Reset mid-pixel.
  - Stimulus: assert RST after 12 bits.
  - Required: all outputs 0 next clock. Remaining bits are ignored. Decoding resumes only after a 600-clk gap.
